card6_bus_tracer: RTL

Synthesizable, parametrised bus trace-capture unit for the CARD6 CPU. It replaces the console-printed address/data bus monitoring and fixed tick-count stop used in simulation with on-chip capture. It samples the CPU address and data buses into a trace buffer, using a selectable qualification mode and a programmable run length, then hands the captured entries out through a read port. It sits beside the `card6` core and taps `adrs_bus`/`data_bus` without driving them.

---
 rtl/card6_bus_tracer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/card6_bus_tracer.sv
// card6_bus_tracer: on-chip trace capture of the CARD6 address/data buses.
// Samples are qualified per mode, stamped with a capture tick and stored in a
// circular buffer that is drained through a one-entry-per-cycle read port.
module card6_bus_tracer #(
  parameter int unsigned ADRS_W = 18,
  parameter int unsigned DATA_W = 6,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned WRAP   = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [ADRS_W-1:0]               adrs_bus,
  input  logic [DATA_W-1:0]               data_bus,
  input  logic                            arm,
  input  logic                            stop,
  input  logic [1:0]                      mode,
  input  logic [ADRS_W-1:0]               match_adrs,
  input  logic [TS_W-1:0]                 stop_ticks,
  input  logic                            rd_en,
  output logic [TS_W+ADRS_W+DATA_W-1:0]   rd_data,
  output logic                            rd_valid,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            empty,
  output logic                            full,
  output logic                            running,
  output logic                            done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SMP_W = ADRS_W + DATA_W;
  localparam int unsigned ENT_W = TS_W + SMP_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam bit WRAP_EN = (WRAP != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DONE} state_t;

  state_t             state, state_next;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [TS_W-1:0]    tick;
  logic [SMP_W-1:0]   last_smp;
  logic               first_smp;
  logic [SMP_W-1:0]   smp_c;
  logic               qual_c, run_end_c, cap_c, pop_c;
  logic [CNT_W-1:0]   count_next;

  assign smp_c     = {adrs_bus, data_bus};
  assign run_end_c = (stop_ticks != '0) && (tick == stop_ticks - TS_W'(1));

  // Sample qualification for the current bus values; mode 3 acts like mode 0
  always_comb begin
    qual_c = 1'b1;
    case (mode)
      2'd1:    qual_c = first_smp || (smp_c != last_smp);
      2'd2:    qual_c = (adrs_bus == match_adrs);
      default: qual_c = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state plus capture/pop strobes; arm overrides everything else
  always_comb begin
    state_next = state;
    cap_c      = 1'b0;
    pop_c      = 1'b0;
    case (state)
      ST_CAPTURE: begin
        cap_c = qual_c;
        if (stop || run_end_c || (!WRAP_EN && cap_c && (count == CNT_LAST)))
          state_next = ST_DONE;
      end
      default: pop_c = rd_en && (count != '0);
    endcase
    if (arm) begin
      state_next = ST_CAPTURE;
      cap_c      = 1'b0;
      pop_c      = 1'b0;
    end
  end

  // Occupancy after this edge; a write into a full wrapping buffer keeps it full
  always_comb begin
    count_next = count;
    if (arm)                               count_next = '0;
    else if (cap_c && (count != CNT_FULL)) count_next = count + CNT_W'(1);
    else if (pop_c)                        count_next = count - CNT_W'(1);
  end

  // Pointers, tick counter, change history and registered status/read outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      tick      <= '0;
      last_smp  <= '0;
      first_smp <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      count    <= count_next;
      empty    <= (count_next == '0);
      full     <= (count_next == CNT_FULL);
      running  <= (state_next == ST_CAPTURE);
      done     <= (state_next == ST_DONE);
      rd_valid <= pop_c;
      if (pop_c) rd_data <= mem[rd_ptr];
      if (arm) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        tick      <= '0;
        last_smp  <= '0;
        first_smp <= 1'b1;
      end else begin
        if (state == ST_CAPTURE) begin
          first_smp <= 1'b0;
          if (tick != '1) tick <= tick + TS_W'(1);
        end
        if (cap_c) begin
          wr_ptr   <= wr_ptr + PTR_W'(1);
          last_smp <= smp_c;
          if (count == CNT_FULL) rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Trace storage; contents need no reset since count gates every read
  always_ff @(posedge clock) begin
    if (cap_c) mem[wr_ptr] <= {tick, smp_c};
  end

endmodule
